dp_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the data-processing path: instruction fetch, register read, barrel shifter, ALU, register and flag writeback. Consumes decoder status (undefined-instruction flag, compare/test flag, S bit) and the condition-check result, and issues one-cycle enable strobes to the IR, PC, register file, shifter, ALU and CPSR flags. Also handles the instruction-memory fetch handshake with a timeout, raises traps, and counts retired instructions.

---
 rtl/dp_multicycle_ctrl_if.sv | 56 +++++
 rtl/dp_multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dp_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_multicycle_ctrl_if.sv
// Bundle between the multi-cycle sequencer and the data-processing path:
// instruction-memory fetch handshake, decoder status inputs and datapath enable strobes.
interface dp_multicycle_ctrl_if;
  // Fetch handshake: imem_req stays high for every FETCH cycle until imem_ack
  // is seen. The instruction word is taken in the cycle where imem_req and
  // imem_ack are both high. imem_ack is ignored outside FETCH.
  logic imem_req;
  logic imem_ack;

  // Decoder status for the instruction held in the IR.
  logic und_ins;
  logic ttcc;
  logic s_bit;
  logic cond_ok;

  // One-cycle datapath enables.
  logic ir_we;
  logic pc_we;
  logic rf_rd;
  logic sh_en;
  logic alu_en;
  logic rf_we;
  logic flags_we;

  modport master (
    output imem_req,
    input  imem_ack,
    input  und_ins,
    input  ttcc,
    input  s_bit,
    input  cond_ok,
    output ir_we,
    output pc_we,
    output rf_rd,
    output sh_en,
    output alu_en,
    output rf_we,
    output flags_we
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output und_ins,
    output ttcc,
    output s_bit,
    output cond_ok,
    input  ir_we,
    input  pc_we,
    input  rf_rd,
    input  sh_en,
    input  alu_en,
    input  rf_we,
    input  flags_we
  );
endinterface

// File: rtl/dp_multicycle_ctrl.sv
// Multi-cycle sequencer for the data-processing path: fetch, decode, register read,
// shift/ALU, writeback, with fetch timeout, trap handling and a retired-instruction counter.
module dp_multicycle_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 trap_clr,
  dp_multicycle_ctrl_if.master bus,
  output logic                 busy,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_UND  = 2'b01;
  localparam logic [1:0] CAUSE_TO   = 2'b10;

  // The counter value seen in the last permitted FETCH cycle.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       ret_inc;
  logic [1:0] cause_set;
  logic       trap_release;

  logic imem_req_c;
  logic ir_we_c;
  logic pc_we_c;
  logic rf_rd_c;
  logic sh_en_c;
  logic alu_en_c;
  logic rf_we_c;
  logic flags_we_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= S_IDLE;
      wait_cnt   <= 8'd0;
      retired    <= '0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (ret_inc) begin
        retired <= retired + 1'b1;
      end
      if (cause_set != CAUSE_NONE) begin
        trap       <= 1'b1;
        trap_cause <= cause_set;
      end else if (trap_release) begin
        trap       <= 1'b0;
        trap_cause <= CAUSE_NONE;
      end
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    wait_nxt     = wait_cnt;
    ret_inc      = 1'b0;
    cause_set    = CAUSE_NONE;
    trap_release = 1'b0;
    imem_req_c   = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    rf_rd_c      = 1'b0;
    sh_en_c      = 1'b0;
    alu_en_c     = 1'b0;
    rf_we_c      = 1'b0;
    flags_we_c   = 1'b0;

    unique case (cur_state)
      S_IDLE: begin
        wait_nxt = 8'd0;
        if (run) begin
          nxt_state = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req_c = 1'b1;
        // An ack in the final permitted cycle still wins over the timeout.
        if (bus.imem_ack) begin
          ir_we_c   = 1'b1;
          pc_we_c   = 1'b1;
          wait_nxt  = 8'd0;
          nxt_state = S_DECODE;
        end else if (wait_cnt >= WAIT_LAST) begin
          wait_nxt  = 8'd0;
          cause_set = CAUSE_TO;
          nxt_state = S_TRAP;
        end else begin
          wait_nxt = 8'(wait_cnt + 8'd1);
        end
      end

      S_DECODE: begin
        if (bus.und_ins) begin
          cause_set = CAUSE_UND;
          nxt_state = S_TRAP;
        end else if (!bus.cond_ok) begin
          ret_inc   = 1'b1;
          nxt_state = run ? S_FETCH : S_IDLE;
        end else begin
          nxt_state = S_READ;
        end
      end

      S_READ: begin
        rf_rd_c   = 1'b1;
        nxt_state = S_EXEC;
      end

      S_EXEC: begin
        sh_en_c   = 1'b1;
        alu_en_c  = 1'b1;
        nxt_state = S_WB;
      end

      S_WB: begin
        // Compare/test ops only update flags; they never write a register.
        rf_we_c    = ~bus.ttcc;
        flags_we_c = bus.s_bit | bus.ttcc;
        ret_inc    = 1'b1;
        nxt_state  = run ? S_FETCH : S_IDLE;
      end

      S_TRAP: begin
        if (trap_clr) begin
          trap_release = 1'b1;
          nxt_state    = S_IDLE;
        end
      end

      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Strobes are held low while rst is high so a reset landing mid-instruction
  // can never leak a write into the datapath.
  assign bus.imem_req = imem_req_c & ~rst;
  assign bus.ir_we    = ir_we_c    & ~rst;
  assign bus.pc_we    = pc_we_c    & ~rst;
  assign bus.rf_rd    = rf_rd_c    & ~rst;
  assign bus.sh_en    = sh_en_c    & ~rst;
  assign bus.alu_en   = alu_en_c   & ~rst;
  assign bus.rf_we    = rf_we_c    & ~rst;
  assign bus.flags_we = flags_we_c & ~rst;

  assign busy  = (cur_state != S_IDLE);
  assign state = cur_state;

endmodule

// File: tb/tb_dp_multicycle_ctrl.sv
// Bench for dp_multicycle_ctrl: directed scenarios then random instructions, each expanded
// into its expected per-cycle trace (state, strobes, trap, retired) from the instruction rules.
module tb_dp_multicycle_ctrl;

  localparam int FT      = 15;
  localparam int CW      = 4;
  localparam int RET_MOD = 1 << CW;

  logic          clk;
  logic          rst;
  logic          run;
  logic          trap_clr;
  logic          busy;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  dp_multicycle_ctrl_if bus ();

  dp_multicycle_ctrl #(
    .FETCH_TIMEOUT(FT),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .trap_clr  (trap_clr),
    .bus       (bus),
    .busy      (busy),
    .trap      (trap),
    .trap_cause(trap_cause),
    .state     (state),
    .retired   (retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int         checks;
  int         errors;
  int         exp_ret;
  logic       exp_trap;
  logic [1:0] exp_cause;
  int         nxt_st;   // where the trace left the DUT: 0 idle, 1 fetch, 6 trap
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance past the rising edge.
  // Strobe order: imem_req ir_we pc_we rf_rd sh_en alu_en rf_we flags_we.
  task automatic cyc(input logic [2:0] es, input logic [7:0] estb, input string tag);
    logic [7:0] e;
    exp_q.push_back(estb);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".strobes"},
          32'({bus.imem_req, bus.ir_we, bus.pc_we, bus.rf_rd,
               bus.sh_en, bus.alu_en, bus.rf_we, bus.flags_we}), 32'(e));
    check({tag, ".busy"}, 32'(busy), 32'(es != 3'd0));
    check({tag, ".trap"}, 32'(trap), 32'(exp_trap));
    check({tag, ".cause"}, 32'(trap_cause), 32'(exp_cause));
    check({tag, ".retired"}, 32'(retired), 32'(exp_ret));
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_reset();
    rst          = 1'b1;
    run          = 1'b0;
    trap_clr     = 1'b0;
    bus.imem_ack = 1'b0;
    bus.und_ins  = 1'b0;
    bus.ttcc     = 1'b0;
    bus.s_bit    = 1'b0;
    bus.cond_ok  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_ret   = 0;
    exp_trap  = 1'b0;
    exp_cause = 2'b00;
    nxt_st    = 0;
  endtask

  task automatic idle(input logic go);
    run = go;
    cyc(3'd0, 8'h00, "idle");
    nxt_st = go ? 1 : 0;
  endtask

  task automatic serve_trap(input int hold);
    for (int i = 0; i < hold; i++) begin
      trap_clr = 1'b0;
      run      = 1'($urandom_range(0, 1));
      cyc(3'd6, 8'h00, "trap_hold");
    end
    trap_clr = 1'b1;
    cyc(3'd6, 8'h00, "trap_clr");
    trap_clr  = 1'b0;
    exp_trap  = 1'b0;
    exp_cause = 2'b00;
    nxt_st    = 0;
  endtask

  task automatic go_fetch();
    int guard;
    guard = 0;
    while (nxt_st != 1 && guard < 8) begin
      if (nxt_st == 6) serve_trap($urandom_range(0, 2));
      else idle(1'b1);
      guard++;
    end
    check("go_fetch_bound", 32'(nxt_st), 32'd1);
  endtask

  // One instruction starting in FETCH, expanded into its expected cycle trace.
  task automatic instr(input int wait_n, input logic und, input logic tt, input logic s,
                       input logic cond, input logic rn);
    bus.und_ins = und;
    bus.ttcc    = tt;
    bus.s_bit   = s;
    bus.cond_ok = cond;
    run         = 1'b1;
    for (int i = 0; i < wait_n && i < FT; i++) begin
      bus.imem_ack = 1'b0;
      cyc(3'd1, 8'h80, "fetch_wait");
    end
    if (wait_n >= FT) begin
      exp_trap  = 1'b1;
      exp_cause = 2'b10;
      nxt_st    = 6;
      return;
    end
    bus.imem_ack = 1'b1;
    cyc(3'd1, 8'hE0, "fetch_ack");
    bus.imem_ack = 1'b0;
    if (!und && !cond) run = rn;
    cyc(3'd2, 8'h00, "decode");
    if (und) begin
      exp_trap  = 1'b1;
      exp_cause = 2'b01;
      nxt_st    = 6;
      return;
    end
    if (!cond) begin
      exp_ret = (exp_ret + 1) % RET_MOD;
      nxt_st  = rn ? 1 : 0;
      return;
    end
    run = rn;
    cyc(3'd3, 8'h10, "read");
    cyc(3'd4, 8'h0C, "exec");
    cyc(3'd5, {6'b0, ~tt, s | tt}, "wb");
    exp_ret = (exp_ret + 1) % RET_MOD;
    nxt_st  = rn ? 1 : 0;
  endtask

  task automatic reset_in_exec();
    bus.und_ins  = 1'b0;
    bus.ttcc     = 1'b0;
    bus.s_bit    = 1'b0;
    bus.cond_ok  = 1'b1;
    run          = 1'b1;
    bus.imem_ack = 1'b1;
    cyc(3'd1, 8'hE0, "rx_fetch");
    bus.imem_ack = 1'b0;
    cyc(3'd2, 8'h00, "rx_decode");
    cyc(3'd3, 8'h10, "rx_read");
    rst = 1'b1;
    cyc(3'd4, 8'h00, "rx_exec_rst");
    rst       = 1'b0;
    exp_ret   = 0;
    exp_trap  = 1'b0;
    exp_cause = 2'b00;
    run       = 1'b0;
    cyc(3'd0, 8'h00, "rx_post_rst");
    cyc(3'd0, 8'h00, "rx_post_rst2");
    nxt_st = 0;
  endtask

  initial begin
    int r;
    int wt;
    checks = 0;
    errors = 0;

    do_reset();
    cyc(3'd0, 8'h00, "reset_idle");
    idle(1'b1);

    // ADD, S=0, zero-wait: 1,2,3,4,5 then back to FETCH
    instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("retired_after_add", 32'(retired), 32'd1);
    instr(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);   // ADDS
    instr(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);   // CMP
    instr(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);   // TST, S=0
    instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // condition skip
    instr(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // undefined beats cond_ok=0
    go_fetch();
    instr(FT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // fetch timeout
    go_fetch();
    instr(FT - 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); // ack on last cycle
    instr(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // run dropped in READ
    check("run_drop_idle", 32'(nxt_st), 32'd0);
    go_fetch();
    reset_in_exec();
    go_fetch();

    // counter wrap at 2**CW retirements
    for (int i = 0; i < RET_MOD; i++) instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("retired_wrap", 32'(retired), 32'd0);

    // random instruction stream
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 19);
      if (r == 18) wt = FT;
      else if (r == 19) wt = FT - 1;
      else wt = r % 4;
      instr(wt,
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 5) != 0));
      go_fetch();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
